// File: rtl/sl_preceptron_pkg.sv
// sl_preceptron_pkg: shared FSM states and MAC interface timing for the vector streamer
package sl_preceptron_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_LOAD, ST_STREAM, ST_GAP} state_t;
  localparam int MAC_START_TO_DATA = 2;
  localparam int MAC_RECOVERY = 1;
endpackage

// File: rtl/sl_preceptron_vector_streamer_if.sv
// sl_preceptron_vector_streamer_if: valid/ready sample stream with end-of-vector marker
interface sl_preceptron_vector_streamer_if #(parameter int DW = 8);
  logic s_valid;
  logic s_ready;
  logic s_last;
  logic [DW-1:0] s_data;
  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/sl_preceptron_stream_fifo.sv
// sl_preceptron_stream_fifo: first-word-fall-through synchronous FIFO with occupancy output
module sl_preceptron_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic [LW-1:0]    level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic push_ok, pop_ok;
  assign full_o = level_q == LW'(DEPTH);
  assign push_ok = push_i && !full_o;
  assign pop_ok = pop_i && level_q != '0;
  assign dout_o = mem_q[rd_q];
  assign level_o = level_q;
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_ok);
      rd_q <= rd_q + AW'(pop_ok);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end
endmodule

// File: rtl/sl_preceptron_vector_streamer.sv
// sl_preceptron_vector_streamer: buffers framed sample vectors and replays whole vectors to the MAC with fixed timing
module sl_preceptron_vector_streamer
  import sl_preceptron_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 8,
  parameter int VECTOR_LENGTH = 64,
  parameter int FIFO_DEPTH = 128,
  parameter int CNT_WIDTH = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sl_preceptron_vector_streamer_if.slave s,
  input  logic                     cfg_clear_error,
  output logic                     start_vector_processing,
  output logic                     data_valid,
  output logic [DATA_IN_WIDTH-1:0] data_in,
  output logic                     done_vector_processing,
  output logic [LW-1:0]            status_fifo_level,
  output logic                     status_busy,
  output logic [CNT_WIDTH-1:0]     status_vectors_sent,
  output logic                     status_frame_error
);
  localparam int IW = $clog2(VECTOR_LENGTH);
  state_t state_q, state_d;
  logic [IW-1:0] in_idx_q, in_idx_d, cnt_q, cnt_d;
  logic [LW-1:0] pend_q, pend_d, level;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic [DATA_IN_WIDTH-1:0] data_q, data_d, head;
  logic err_q, err_d, start_q, start_d, dv_q, dv_d, done_q, done_d;
  logic full, push, pop, in_end, complete, bad_frame, discard, last_beat;
  sl_preceptron_stream_fifo #(.WIDTH(DATA_IN_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (s.s_data),
    .dout_o  (head),
    .full_o  (full),
    .level_o (level)
  );
  assign s.s_ready = !full;
  assign push = s.s_valid && !full;
  assign in_end = in_idx_q == IW'(VECTOR_LENGTH - 1);
  assign complete = push && in_end;
  assign bad_frame = push && (s.s_last != in_end);
  // entries beyond the pending whole vectors and the vector being assembled are orphans of a framing error
  assign discard = state_q == ST_IDLE && (level - LW'(in_idx_q) > pend_q * LW'(VECTOR_LENGTH));
  assign last_beat = state_q == ST_STREAM && cnt_q == IW'(VECTOR_LENGTH - 1);
  assign pop = discard || state_q == ST_STREAM;
  always_comb begin
    in_idx_d = push ? ((s.s_last || in_end) ? '0 : in_idx_q + 1'b1) : in_idx_q;
    pend_d = pend_q + LW'(complete) - LW'(last_beat);
    sent_d = sent_q + CNT_WIDTH'(last_beat);
    err_d = bad_frame || (err_q && !cfg_clear_error);
    start_d = state_q == ST_START;
    dv_d = state_q == ST_STREAM;
    data_d = dv_d ? head : data_q;
    done_d = last_beat;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: state_d = (!discard && pend_q != '0) ? ST_START : ST_IDLE;
      ST_START: begin
        state_d = ST_LOAD;
        cnt_d = '0;
      end
      ST_LOAD: begin
        state_d = cnt_q == IW'(MAC_START_TO_DATA - 2) ? ST_STREAM : ST_LOAD;
        cnt_d = cnt_q == IW'(MAC_START_TO_DATA - 2) ? '0 : cnt_q + 1'b1;
      end
      ST_STREAM: begin
        state_d = last_beat ? ST_GAP : ST_STREAM;
        cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      end
      ST_GAP: begin
        state_d = cnt_q == IW'(MAC_RECOVERY - 1) ? ST_IDLE : ST_GAP;
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      in_idx_q <= '0;
      pend_q <= '0;
      sent_q <= '0;
      err_q <= 1'b0;
      start_q <= 1'b0;
      dv_q <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      in_idx_q <= in_idx_d;
      pend_q <= pend_d;
      sent_q <= sent_d;
      err_q <= err_d;
      start_q <= start_d;
      dv_q <= dv_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end
  assign start_vector_processing = start_q;
  assign data_valid = dv_q;
  assign data_in = data_q;
  assign done_vector_processing = done_q;
  assign status_fifo_level = level;
  assign status_busy = state_q != ST_IDLE;
  assign status_vectors_sent = sent_q;
  assign status_frame_error = err_q;
endmodule

// File: tb/tb_sl_preceptron_vector_streamer.sv
// tb_sl_preceptron_vector_streamer: scoreboard bench with a weighted-sum MAC model on the streamer output
module tb_sl_preceptron_vector_streamer;
  localparam int DW = 8, VL = 64, DEPTH = 128, CW = 16, LW = 8;
  logic clk = 1'b0, rst_n = 1'b1, cfg_clear_error = 1'b0;
  logic start_vector_processing, data_valid, done_vector_processing, status_busy, status_frame_error;
  logic [DW-1:0] data_in, mon_exp;
  logic [LW-1:0] status_fifo_level;
  logic [CW-1:0] status_vectors_sent;
  int total = 0, bad = 0, cyc = 0, beat = 0, last_start = 0;
  longint acc = 0, mon_sum = 0;
  bit full_seen = 1'b0;
  logic [DW-1:0] exp_q[$];
  longint sum_q[$];
  int start_cyc[$];

  sl_preceptron_vector_streamer_if #(.DW(DW)) s ();

  sl_preceptron_vector_streamer #(
    .DATA_IN_WIDTH(DW), .VECTOR_LENGTH(VL), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .s                       (s),
    .cfg_clear_error         (cfg_clear_error),
    .start_vector_processing (start_vector_processing),
    .data_valid              (data_valid),
    .data_in                 (data_in),
    .done_vector_processing  (done_vector_processing),
    .status_fifo_level       (status_fifo_level),
    .status_busy             (status_busy),
    .status_vectors_sent     (status_vectors_sent),
    .status_frame_error      (status_frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC model: checks beat timing against the start pulse, data order, done placement and weighted sums
  always @(negedge clk) begin
    if (!rst_n) begin
      beat = 0;
      acc = 0;
    end else begin
      if (start_vector_processing) begin
        start_cyc.push_back(cyc);
        last_start = cyc;
        beat = 0;
        acc = 0;
      end
      if (data_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL data_unexpected beat=%0d got=%0h", beat, data_in);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_in !== mon_exp) begin
            bad++;
            $display("FAIL data beat=%0d got=%0h exp=%0h", beat, data_in, mon_exp);
          end
        end
        total++;
        if (cyc !== last_start + 2 + beat) begin
          bad++;
          $display("FAIL beat_timing beat=%0d got_cyc=%0d exp_cyc=%0d", beat, cyc, last_start + 2 + beat);
        end
        total++;
        if (done_vector_processing !== (beat == VL - 1)) begin
          bad++;
          $display("FAIL done_position beat=%0d got=%b exp=%b", beat, done_vector_processing, beat == VL - 1);
        end
        acc += longint'(data_in) * (beat + 1);
        beat++;
        if (beat == VL) begin
          mon_sum = sum_q.size() != 0 ? sum_q.pop_front() : -1;
          total++;
          if (acc !== mon_sum) begin
            bad++;
            $display("FAIL mac_sum got=%0d exp=%0d", acc, mon_sum);
          end
        end
      end else begin
        total++;
        if (done_vector_processing !== 1'b0) begin
          bad++;
          $display("FAIL done_stray got=%b exp=0", done_vector_processing);
        end
      end
    end
  end

  task automatic push_sample(input logic [DW-1:0] d, input logic l);
    int w = 0;
    s.s_valid = 1'b1;
    s.s_data = d;
    s.s_last = l;
    while (s.s_ready !== 1'b1 && w < 2000) begin
      full_seen = 1'b1;
      total++;
      if (status_fifo_level !== LW'(DEPTH)) begin
        bad++;
        $display("FAIL ready_low_level got=%0d exp=%0d", status_fifo_level, DEPTH);
      end
      @(negedge clk);
      w++;
    end
    if (s.s_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL push_timeout got_ready=%b exp=1", s.s_ready);
    end
    @(negedge clk);
    s.s_valid = 1'b0;
    s.s_last = 1'b0;
  endtask

  task automatic push_vec(input int n, input int last_at, input bit rnd, input logic [DW-1:0] base);
    logic [DW-1:0] v[$];
    logic [DW-1:0] d;
    longint sm = 0;
    for (int i = 0; i < n; i++) begin
      d = rnd ? DW'($urandom) : base + DW'(i);
      push_sample(d, i == last_at);
      v.push_back(d);
    end
    if (n == VL) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(v[i]);
        sm += longint'(v[i]) * (i + 1);
      end
      sum_q.push_back(sm);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((status_busy || status_fifo_level != '0 || exp_q.size() != 0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (w >= 5000) begin
      bad++;
      $display("FAIL idle_timeout busy=%b level=%0d pending=%0d exp=idle", status_busy, status_fifo_level, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    s.s_valid = 1'b1;
    s.s_data = 8'h5a;
    s.s_last = 1'b1;
    cfg_clear_error = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({start_vector_processing, data_valid, done_vector_processing, status_busy, status_frame_error} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000", {start_vector_processing, data_valid, done_vector_processing, status_busy, status_frame_error});
    end
    total++;
    if (data_in !== '0 || status_fifo_level !== '0 || status_vectors_sent !== '0) begin
      bad++;
      $display("FAIL reset_values got data=%0h level=%0d sent=%0d exp=0", data_in, status_fifo_level, status_vectors_sent);
    end
    total++;
    if (s.s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", s.s_ready);
    end
    s.s_valid = 1'b0;
    s.s_last = 1'b0;
    cfg_clear_error = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (status_fifo_level !== '0 || status_busy !== 1'b0 || s.s_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset got level=%0d busy=%b ready=%b exp 0/0/1", status_fifo_level, status_busy, s.s_ready);
    end
  endtask

  task automatic test_single();
    start_cyc.delete();
    push_vec(VL, VL - 1, 1'b0, 8'd1);
    wait_idle();
    total++;
    if (start_cyc.size() !== 1) begin
      bad++;
      $display("FAIL single_starts got=%0d exp=1", start_cyc.size());
    end
    total++;
    if (status_vectors_sent !== CW'(1)) begin
      bad++;
      $display("FAIL single_sent got=%0d exp=1", status_vectors_sent);
    end
    total++;
    if (data_valid !== 1'b0 || data_in !== 8'd64) begin
      bad++;
      $display("FAIL single_hold got dv=%b data=%0d exp dv=0 data=64", data_valid, data_in);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    start_cyc.delete();
    push_vec(VL, VL - 1, 1'b1, 8'd0);
    push_vec(VL, VL - 1, 1'b1, 8'd0);
    wait_idle();
    d = start_cyc.size() >= 2 ? start_cyc[1] - start_cyc[0] : -1;
    total++;
    if (start_cyc.size() !== 2 || d !== VL + 4) begin
      bad++;
      $display("FAIL b2b_spacing got starts=%0d gap=%0d exp starts=2 gap=%0d", start_cyc.size(), d, VL + 4);
    end
    total++;
    if (status_vectors_sent !== CW'(3)) begin
      bad++;
      $display("FAIL b2b_sent got=%0d exp=3", status_vectors_sent);
    end
  endtask

  task automatic test_full();
    int nv = 0;
    logic [CW-1:0] base_sent = status_vectors_sent;
    full_seen = 1'b0;
    while (!full_seen && nv < 40) begin
      push_vec(VL, VL - 1, 1'b1, 8'd0);
      nv++;
    end
    total++;
    if (!full_seen) begin
      bad++;
      $display("FAIL full_never_reached got_vectors=%0d exp_full=1", nv);
    end
    wait_idle();
    total++;
    if (status_vectors_sent !== base_sent + CW'(nv)) begin
      bad++;
      $display("FAIL full_sent got=%0d exp=%0d", status_vectors_sent, base_sent + CW'(nv));
    end
  endtask

  task automatic test_framing();
    logic [CW-1:0] base_sent = status_vectors_sent;
    total++;
    if (status_frame_error !== 1'b0) begin
      bad++;
      $display("FAIL frame_initial got=%b exp=0", status_frame_error);
    end
    push_vec(10, 9, 1'b1, 8'd0);
    total++;
    if (status_frame_error !== 1'b1) begin
      bad++;
      $display("FAIL frame_short got=%b exp=1", status_frame_error);
    end
    push_vec(VL, VL - 1, 1'b0, 8'd100);
    wait_idle();
    total++;
    if (status_frame_error !== 1'b1 || status_vectors_sent !== base_sent + CW'(1)) begin
      bad++;
      $display("FAIL frame_sticky got err=%b sent=%0d exp err=1 sent=%0d", status_frame_error, status_vectors_sent, base_sent + CW'(1));
    end
    cfg_clear_error = 1'b1;
    @(negedge clk);
    cfg_clear_error = 1'b0;
    total++;
    if (status_frame_error !== 1'b0) begin
      bad++;
      $display("FAIL frame_clear got=%b exp=0", status_frame_error);
    end
    push_vec(VL, -1, 1'b1, 8'd0);
    total++;
    if (status_frame_error !== 1'b1) begin
      bad++;
      $display("FAIL frame_missing_last got=%b exp=1", status_frame_error);
    end
    wait_idle();
    total++;
    if (status_vectors_sent !== base_sent + CW'(2)) begin
      bad++;
      $display("FAIL frame_missing_last_sent got=%0d exp=%0d", status_vectors_sent, base_sent + CW'(2));
    end
    cfg_clear_error = 1'b1;
    @(negedge clk);
    cfg_clear_error = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w = 0;
    int st;
    start_cyc.delete();
    push_vec(VL, VL - 1, 1'b1, 8'd0);
    while (start_cyc.size() == 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    st = start_cyc.size() != 0 ? start_cyc[0] : cyc;
    while (cyc < st + 20) @(negedge clk);
    total++;
    if (data_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_streaming got dv=%b exp=1", data_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({start_vector_processing, data_valid, done_vector_processing, status_busy} !== 4'b0 || data_in !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%b data=%0h exp=0000 data=0", {start_vector_processing, data_valid, done_vector_processing, status_busy}, data_in);
    end
    total++;
    if (status_fifo_level !== '0 || status_vectors_sent !== '0 || s.s_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_status got level=%0d sent=%0d ready=%b exp 0/0/1", status_fifo_level, status_vectors_sent, s.s_ready);
    end
    exp_q.delete();
    sum_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    total++;
    if (start_cyc.size() !== 1 || status_fifo_level !== '0) begin
      bad++;
      $display("FAIL mid_no_restart got starts=%0d level=%0d exp starts=1 level=0", start_cyc.size(), status_fifo_level);
    end
    push_vec(VL, VL - 1, 1'b1, 8'd0);
    wait_idle();
    total++;
    if (start_cyc.size() !== 2 || status_vectors_sent !== CW'(1)) begin
      bad++;
      $display("FAIL mid_recover got starts=%0d sent=%0d exp starts=2 sent=1", start_cyc.size(), status_vectors_sent);
    end
  endtask

  initial begin
    s.s_valid = 1'b0;
    s.s_data = '0;
    s.s_last = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_framing();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
